// File: rtl/b2a_sched.sv
// Issue/sequencing controller for a SecB2A Boolean-to-arithmetic converter.
// Round-robin request issue, gated on fresh randomness, with a valid/ID shadow pipeline.
module b2a_sched #(
  parameter int K_WIDTH  = 16,
  parameter int N_SHARES = 3,
  parameter int N_REQ    = 2,
  parameter int LATENCY  = 11,
  localparam int ID_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int CNT_W   = $clog2(LATENCY + 1),
  localparam int DW      = K_WIDTH * N_SHARES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ*DW-1:0]   req_data,
  output logic [N_REQ-1:0]      req_ready,
  input  logic                  rnd_valid,
  output logic                  rnd_ready,
  output logic                  dp_ena,
  output logic                  dp_dvld,
  output logic [DW-1:0]         dp_i_b,
  input  logic                  dp_ovld,
  input  logic [DW-1:0]         dp_o_a,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic [DW-1:0]         o_data,
  output logic [ID_W-1:0]       o_id,
  output logic [CNT_W-1:0]      inflight,
  output logic                  err_sync
);

  // Handshakes: a transfer happens on a cycle where valid and ready are both high.
  // Requesters and the randomness source hold valid/data until ready; ready is a
  // same-cycle strobe. The result side advances only together with the pipeline.

  localparam logic [ID_W:0]   N_REQ_W = (ID_W + 1)'(N_REQ);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

  logic            sh_valid [LATENCY];
  logic [ID_W-1:0] sh_id    [LATENCY];
  logic [ID_W-1:0] ptr;
  logic [CNT_W-1:0] cnt;

  logic            stall;
  logic            found;
  logic            grant;
  logic [ID_W-1:0] gnt_idx;
  logic [ID_W:0]   scan_sum;
  logic [ID_W-1:0] scan_idx;

  assign stall     = sh_valid[LATENCY-1] & ~o_ready;
  assign dp_ena    = rnd_valid & ~stall;
  assign rnd_ready = dp_ena;

  // First requesting index at or above the pointer, wrapping around.
  always_comb begin
    found    = 1'b0;
    gnt_idx  = '0;
    scan_sum = '0;
    scan_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_sum = {1'b0, ptr} + (ID_W + 1)'(k);
      if (scan_sum >= N_REQ_W) scan_idx = ID_W'(scan_sum - N_REQ_W);
      else                     scan_idx = ID_W'(scan_sum);
      if (!found && req_valid[scan_idx]) begin
        found   = 1'b1;
        gnt_idx = scan_idx;
      end
    end
  end

  assign grant   = found & dp_ena;
  assign dp_dvld = grant;
  assign dp_i_b  = grant ? req_data[gnt_idx*DW +: DW] : '0;

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        sh_valid[i] <= 1'b0;
        sh_id[i]    <= '0;
      end
      ptr      <= '0;
      cnt      <= '0;
      err_sync <= 1'b0;
    end else begin
      // The converter's own output valid must track our shadow tail exactly.
      err_sync <= err_sync | (dp_ovld ^ sh_valid[LATENCY-1]);
      if (dp_ena) begin
        sh_valid[0] <= grant;
        sh_id[0]    <= grant ? gnt_idx : '0;
        for (int i = 1; i < LATENCY; i++) begin
          sh_valid[i] <= sh_valid[i-1];
          sh_id[i]    <= sh_id[i-1];
        end
        if (grant) ptr <= (gnt_idx == LAST_ID) ? '0 : gnt_idx + 1'b1;
        cnt <= cnt + CNT_W'(grant) - CNT_W'(sh_valid[LATENCY-1]);
      end
    end
  end

  assign o_valid  = sh_valid[LATENCY-1];
  assign o_id     = sh_id[LATENCY-1];
  assign o_data   = dp_o_a;
  assign inflight = cnt;

endmodule

// File: tb/tb_b2a_sched.sv
// Bench for b2a_sched: converter stand-in, job-level reference model checked every
// cycle, and directed scenarios with hand-computed grant order and latencies.
module tb_b2a_sched;
  localparam int K = 16, NS = 3, NR = 2, LAT = 11, IDW = 1, CW = 4, DW = K * NS;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_ready;
  logic              rnd_valid, rnd_ready, dp_ena, dp_dvld;
  logic [DW-1:0]     dp_i_b, dp_o_a, o_data;
  logic              dp_ovld, o_valid, o_ready;
  logic [IDW-1:0]    o_id;
  logic [CW-1:0]     inflight;
  logic              err_sync;
  logic              force_ovld;

  b2a_sched #(.K_WIDTH(K), .N_SHARES(NS), .N_REQ(NR), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
    .dp_ena(dp_ena), .dp_dvld(dp_dvld), .dp_i_b(dp_i_b), .dp_ovld(dp_ovld),
    .dp_o_a(dp_o_a), .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data),
    .o_id(o_id), .inflight(inflight), .err_sync(err_sync)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish (got running, required done)");
    $fatal(1);
  end

  // Converter stand-in: LAT enabled stages, re-masked arithmetic shares.
  logic          cv_v [LAT];
  logic [DW-1:0] cv_d [LAT];

  function automatic logic [DW-1:0] to_arith(input logic [DW-1:0] b, input logic [31:0] r);
    logic [15:0] x;
    x = b[15:0] ^ b[31:16] ^ b[47:32];
    return {r[31:16], r[15:0], 16'(x - r[15:0] - r[31:16])};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) begin
        cv_v[i] <= 1'b0;
        cv_d[i] <= '0;
      end
    end else if (dp_ena) begin
      cv_v[0] <= dp_dvld;
      cv_d[0] <= to_arith(dp_i_b, $urandom());
      for (int i = 1; i < LAT; i++) begin
        cv_v[i] <= cv_v[i-1];
        cv_d[i] <= cv_d[i-1];
      end
    end
  end

  assign dp_ovld = cv_v[LAT-1] | force_ovld;
  assign dp_o_a  = cv_d[LAT-1];

  // scoreboard
  int n_pass = 0, n_chk = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  // Reference model: list of jobs, each with enabled cycles left before it is visible.
  logic [IDW+15:0] exp_q[$];
  int              left_q[$];
  int              m_ptr = 0;
  logic            m_err = 1'b0;

  // Observation logs taken from DUT outputs.
  int          tcyc = 0;
  int          acc_id_q[$], acc_t_q[$], pend_t_q[$], out_id_q[$], out_lat_q[$], out_t_q[$];
  logic [15:0] out_sum_q[$];
  int          vis_t = 0;
  bit          seen_vis = 0, prev_stall = 0;
  logic [DW-1:0]  prev_o_data;
  logic [IDW-1:0] prev_o_id;
  logic [NR-1:0]  rr_seen;

  always @(negedge clk) begin
    bit ev, st, en, gf;
    int g;
    logic [NR-1:0] exp_rr;
    logic [DW-1:0] exp_in;
    logic [15:0]   sum;
    if (!rst_n) begin
      exp_q.delete(); left_q.delete(); pend_t_q.delete();
      m_ptr = 0; m_err = 1'b0; seen_vis = 0; prev_stall = 0;
      chk("rst_o_data", o_data, '0);
    end
    ev = (exp_q.size() > 0) && (left_q[0] == 0);
    st = ev && !o_ready;
    en = rnd_valid && !st;
    gf = 0; g = 0;
    if (en) begin
      for (int k = 0; k < NR; k++) begin
        if (!gf && req_valid[(m_ptr + k) % NR]) begin
          gf = 1; g = (m_ptr + k) % NR;
        end
      end
    end
    exp_rr = '0;
    if (gf) exp_rr[g] = 1'b1;
    exp_in = gf ? req_data[g*DW +: DW] : '0;
    sum = 16'(o_data[15:0] + o_data[31:16] + o_data[47:32]);
    chk("req_ready", req_ready, exp_rr);
    chk("rnd_ready", rnd_ready, en);
    chk("dp_ena", dp_ena, en);
    chk("dp_dvld", dp_dvld, gf);
    chk("dp_i_b", dp_i_b, exp_in);
    chk("o_valid", o_valid, ev);
    chk("inflight", inflight, exp_q.size());
    chk("err_sync", err_sync, m_err);
    if (ev) begin
      chk("o_id", o_id, exp_q[0][16]);
      chk("o_sum", sum, exp_q[0][15:0]);
    end
    if (prev_stall) begin
      chk("hold_o_data", o_data, prev_o_data);
      chk("hold_o_id", o_id, prev_o_id);
    end
    if (rst_n) begin
      if (req_ready != '0) begin
        acc_id_q.push_back(req_ready[1] ? 1 : 0);
        acc_t_q.push_back(tcyc);
        pend_t_q.push_back(tcyc);
      end
      if (o_valid && !seen_vis) begin
        seen_vis = 1; vis_t = tcyc;
      end
      if (o_valid && o_ready && dp_ena) begin
        out_id_q.push_back(int'(o_id));
        out_sum_q.push_back(sum);
        out_t_q.push_back(tcyc);
        if (pend_t_q.size() > 0) out_lat_q.push_back(vis_t - pend_t_q.pop_front());
        else out_lat_q.push_back(-1);
        seen_vis = 0;
      end
      m_err = m_err | (dp_ovld != ev);
      if (en) begin
        if (ev) begin
          void'(exp_q.pop_front()); void'(left_q.pop_front());
        end
        foreach (left_q[j]) if (left_q[j] > 0) left_q[j]--;
        if (gf) begin
          exp_q.push_back({1'(g), exp_in[15:0] ^ exp_in[31:16] ^ exp_in[47:32]});
          left_q.push_back(LAT - 1);
          m_ptr = (g + 1) % NR;
        end
      end
    end
    prev_stall  = rst_n && o_valid && !o_ready;
    prev_o_data = o_data;
    prev_o_id   = o_id;
  end

  // driver tasks
  int            pend[NR];
  logic [DW-1:0] cur[NR];

  function automatic logic [DW-1:0] rand_shares();
    return {16'($urandom()), 16'($urandom()), 16'($urandom())};
  endfunction

  task automatic run(input int n, input int rlo = -1, input int rhi = -1,
                     input int olo = -1, input int ohi = -1);
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < NR; i++) begin
        req_valid[i]          = pend[i] > 0;
        req_data[i*DW +: DW]  = cur[i];
      end
      rnd_valid = !(c >= rlo && c <= rhi);
      o_ready   = !(c >= olo && c <= ohi);
      tcyc++;
      @(negedge clk);
      rr_seen = req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < NR; i++) begin
        if (rr_seen[i]) begin
          pend[i]--;
          cur[i] = rand_shares();
        end
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; rnd_valid = 1'b0; o_ready = 1'b0; req_valid = '0; force_ovld = 1'b0;
    for (int i = 0; i < NR; i++) pend[i] = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    acc_id_q.delete(); acc_t_q.delete(); out_id_q.delete();
    out_lat_q.delete(); out_t_q.delete(); out_sum_q.delete();
  endtask

  int t0;
  int t3_acc[6] = '{0, 1, 5, 6, 7, 8};
  int t3_lat[6] = '{14, 14, 11, 11, 11, 11};
  int t4_out[8] = '{11, 17, 18, 19, 20, 21, 22, 23};
  int t4_lat[8] = '{11, 11, 16, 16, 16, 16, 16, 16};

  initial begin
    rst_n = 1'b1; force_ovld = 1'b0; req_valid = '0; req_data = '0;
    rnd_valid = 1'b0; o_ready = 1'b0;
    for (int i = 0; i < NR; i++) cur[i] = rand_shares();
    #1;
    do_reset();
    chk("reset_inflight", inflight, 0);
    chk("reset_o_valid", o_valid, 0);
    chk("reset_err_sync", err_sync, 0);
    chk("reset_req_ready", req_ready, 0);

    // single job from requester 0
    cur[0] = {16'hA5A5, 16'h00FF, 16'h1234};
    pend[0] = 1; t0 = tcyc + 1;
    run(20);
    chk("t1_n_acc", acc_t_q.size(), 1);
    chk("t1_n_out", out_id_q.size(), 1);
    if (acc_t_q.size() == 1 && out_id_q.size() == 1) begin
      chk("t1_acc_cycle", acc_t_q[0] - t0, 0);
      chk("t1_o_id", out_id_q[0], 0);
      chk("t1_o_sum", out_sum_q[0], 16'hB76E);
      chk("t1_latency", out_lat_q[0], 11);
      chk("t1_out_cycle", out_t_q[0] - t0, 11);
    end
    chk("t1_inflight_end", inflight, 0);

    // round-robin between both requesters
    do_reset();
    pend[0] = 3; pend[1] = 3; t0 = tcyc + 1;
    run(25);
    chk("t2_n_acc", acc_id_q.size(), 6);
    chk("t2_n_out", out_id_q.size(), 6);
    if (acc_id_q.size() == 6 && out_id_q.size() == 6) begin
      for (int k = 0; k < 6; k++) begin
        chk("t2_grant_id", acc_id_q[k], k % 2);
        chk("t2_out_id", out_id_q[k], k % 2);
        chk("t2_latency", out_lat_q[k], 11);
        chk("t2_out_cycle", out_t_q[k] - t0, 11 + k);
      end
    end

    // randomness starvation for 3 cycles
    do_reset();
    pend[0] = 6; t0 = tcyc + 1;
    run(30, 2, 4);
    chk("t3_n_acc", acc_t_q.size(), 6);
    chk("t3_n_out", out_id_q.size(), 6);
    if (acc_t_q.size() == 6 && out_id_q.size() == 6) begin
      for (int k = 0; k < 6; k++) begin
        chk("t3_acc_cycle", acc_t_q[k] - t0, t3_acc[k]);
        chk("t3_latency", out_lat_q[k], t3_lat[k]);
      end
    end

    // output backpressure for 5 cycles
    do_reset();
    pend[0] = 8; t0 = tcyc + 1;
    run(40, -1, -1, 12, 16);
    chk("t4_n_out", out_id_q.size(), 8);
    if (out_id_q.size() == 8) begin
      for (int k = 0; k < 8; k++) begin
        chk("t4_out_cycle", out_t_q[k] - t0, t4_out[k]);
        chk("t4_latency", out_lat_q[k], t4_lat[k]);
      end
    end

    // reset with jobs in flight
    do_reset();
    pend[0] = 20;
    run(7);
    chk("t5_inflight_before", inflight, 7);
    rst_n = 1'b0;
    #1;
    chk("t5_inflight_async", inflight, 0);
    chk("t5_o_valid_async", o_valid, 0);
    do_reset();
    pend[0] = 1; t0 = tcyc + 1;
    run(20);
    chk("t5_n_out", out_lat_q.size(), 1);
    if (out_lat_q.size() == 1) chk("t5_latency", out_lat_q[0], 11);
    chk("t5_inflight_end", inflight, 0);

    // converter valid out of step with the shadow tail
    force_ovld = 1'b1;
    run(1);
    force_ovld = 1'b0;
    chk("t6_err_set", err_sync, 1);
    run(5);
    chk("t6_err_sticky", err_sync, 1);
    do_reset();
    chk("t6_err_cleared", err_sync, 0);
    run(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
